fetch_stage: RTL

Instruction-fetch stage of the 5-stage pipeline. It is the producing end of the IF/ID interface that decode consumes. It owns the PC and the instruction-memory request handshake. It drives the IF/ID register (instruction, pc, pc+2) and obeys decode's stall controls (pcWriteEn, IFIDWriteEn) and redirect controls (if_flush, next_pc). It stops fetching after a HALT is fetched or a misaligned PC is issued.

---
 rtl/fetch_pkg.sv | 30 +++
 rtl/ifid_reg.sv | 40 ++++
 rtl/fetch_stage.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 16;
  localparam int unsigned OPC_W = 5;

  localparam logic [XLEN-1:0]  RESET_PC_DEF  = 16'h0000;
  localparam logic [XLEN-1:0]  NOP_INSTR_DEF = 16'h0800;
  localparam logic [OPC_W-1:0] HALT_OPCODE   = 5'b00000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DRAIN,
    S_HALT
  } fetch_state_e;

  // IF/ID payload handed to decode
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_two;
  } ifid_t;

  function automatic logic is_halt(input logic [XLEN-1:0] instr);
    return instr[XLEN-1 -: OPC_W] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: load enable, synchronous flush-to-bubble, async reset.
module ifid_reg
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load_i,
  input  logic  flush_i,
  input  ifid_t data_i,
  output ifid_t data_o,
  output logic  valid_o
);

  ifid_t data_q;
  logic  valid_q;

  // Flush wins over load so a redirect always leaves a bubble behind
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q.instr       <= NOP_INSTR;
      data_q.pc          <= '0;
      data_q.pc_plus_two <= '0;
      valid_q            <= 1'b0;
    end else if (flush_i) begin
      data_q.instr       <= NOP_INSTR;
      data_q.pc          <= '0;
      data_q.pc_plus_two <= '0;
      valid_q            <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, the imem request handshake and the IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter int unsigned     PC_INC    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pcWriteEn,
  input  logic            IFIDWriteEn,
  input  logic            if_flush,
  input  logic [XLEN-1:0] next_pc,
  output logic            imem_rd,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_data,
  input  logic            imem_done,
  output logic [XLEN-1:0] IFID_Instr,
  output logic [XLEN-1:0] IFID_PC,
  output logic [XLEN-1:0] IFID_PC_plus_two,
  output logic            IFID_valid,
  output logic            err
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0] hold_q, hold_d;
  logic            err_q, err_d;

  logic            advance, qflush;
  logic [XLEN-1:0] pc_plus;
  logic            deliver, issue;
  logic [XLEN-1:0] deliver_word, issue_addr;
  logic            ifid_load, ifid_flush;
  ifid_t           ifid_in, ifid_out;

  assign advance = pcWriteEn & IFIDWriteEn;
  // A flush with IF/ID frozen is dropped; decode re-raises it next cycle
  assign qflush  = if_flush & IFIDWriteEn;
  assign pc_plus = pc_q + XLEN'(PC_INC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      hold_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      hold_q     <= hold_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    hold_d       = hold_q;
    err_d        = err_q;
    ifid_flush   = 1'b0;
    ifid_load    = 1'b0;
    deliver      = 1'b0;
    deliver_word = hold_q;
    issue        = 1'b0;
    issue_addr   = pc_q;

    case (state_q)
      S_IDLE: begin
        issue = 1'b1;
        if (qflush) begin
          ifid_flush = 1'b1;
          pc_d       = next_pc;
          issue_addr = next_pc;
        end
      end
      S_REQ: begin
        if (qflush) begin
          ifid_flush = 1'b1;
          pc_d       = next_pc;
          if (imem_done) begin
            issue      = 1'b1;
            issue_addr = next_pc;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (imem_done) begin
          if (advance) begin
            deliver      = 1'b1;
            deliver_word = imem_data;
          end else begin
            hold_d  = imem_data;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (qflush) begin
          ifid_flush = 1'b1;
          pc_d       = next_pc;
          issue      = 1'b1;
          issue_addr = next_pc;
        end else if (advance) begin
          deliver = 1'b1;
        end
      end
      // Requests are never aborted: wait out the stale one, keep the newest target
      S_DRAIN: begin
        if (qflush) begin
          ifid_flush = 1'b1;
          pc_d       = next_pc;
        end else if (imem_done) begin
          issue      = 1'b1;
          issue_addr = pc_q;
        end
      end
      S_HALT: begin
        if (qflush) begin
          ifid_flush = 1'b1;
          pc_d       = next_pc;
          issue      = 1'b1;
          issue_addr = next_pc;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (deliver) begin
      ifid_load = 1'b1;
      pc_d      = pc_plus;
      if (is_halt(deliver_word)) begin
        state_d = S_HALT;
      end else begin
        issue      = 1'b1;
        issue_addr = pc_plus;
      end
    end

    // A misaligned target is never put on the bus
    if (issue) begin
      if (issue_addr[0]) begin
        err_d      = 1'b1;
        state_d    = S_HALT;
        ifid_flush = 1'b1;
      end else begin
        state_d    = S_REQ;
        req_addr_d = issue_addr;
      end
    end
  end

  assign ifid_in.instr       = deliver_word;
  assign ifid_in.pc          = pc_q;
  assign ifid_in.pc_plus_two = pc_plus;

  ifid_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .data_i  (ifid_in),
    .data_o  (ifid_out),
    .valid_o (IFID_valid)
  );

  assign imem_rd          = (state_q == S_REQ) || (state_q == S_DRAIN);
  assign imem_addr        = req_addr_q;
  assign IFID_Instr       = ifid_out.instr;
  assign IFID_PC          = ifid_out.pc;
  assign IFID_PC_plus_two = ifid_out.pc_plus_two;
  assign err              = err_q;

endmodule
